// File: rtl/aligner_axis_out_buffer.sv
// rtl/aligner_axis_out_buffer.sv - Aligner output FIFO presenting an AXI4-Stream master with frame tracking
module aligner_axis_out_buffer #(
    parameter int DATA_WIDTH  = 256,
    parameter int TKEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [TKEEP_WIDTH-1:0] tkeep_in,
    input  logic [2:0]             flags_in,
    output logic                   aligner_en,
    output logic                   upstream_ready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [CNT_WIDTH-1:0]   frame_count,
    output logic [CNT_WIDTH-1:0]   beat_count,
    output logic                   err_keep
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW1 = PW + 1;
    localparam int EW  = 1 + TKEEP_WIDTH + DATA_WIDTH;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW1-1:0] count;
    logic           full;
    logic           empty;
    logic           wr;
    logic           rd;
    logic [EW-1:0]  head;
    state_t         state_q;
    state_t         state_d;

    assign full  = (count == CW1'(DEPTH));
    assign empty = (count == '0);

    // Advance depends only on registered occupancy, so tready never reaches the Aligner combinationally.
    assign aligner_en     = !full;
    assign upstream_ready = aligner_en & !flags_in[1];

    assign wr = aligner_en & flags_in[2];
    assign rd = m_axis_tvalid & m_axis_tready;

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = !empty;
    assign m_axis_tlast  = empty ? 1'b0 : head[EW-1];
    assign m_axis_tkeep  = empty ? '0 : head[DATA_WIDTH +: TKEEP_WIDTH];
    assign m_axis_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= {flags_in[0], tkeep_in, data_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + CW1'(1);
                2'b01:   count <= count - CW1'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rd) begin
            state_d = m_axis_tlast ? IDLE : IN_FRAME;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_count  <= '0;
            frame_count <= '0;
            err_keep    <= 1'b0;
        end else begin
            if (rd) begin
                if (m_axis_tlast) begin
                    beat_count  <= '0;
                    frame_count <= frame_count + CNT_WIDTH'(1);
                end else if (beat_count != '1) begin
                    beat_count <= beat_count + CNT_WIDTH'(1);
                end
            end
            // A short beat is only legal as the last beat of a frame.
            if (wr && !flags_in[0] && (tkeep_in != '1)) begin
                err_keep <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aligner_axis_out_buffer.sv
// tb/tb_aligner_axis_out_buffer.sv - randomized self-checking bench with a queue reference model
module tb_aligner_axis_out_buffer;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int D  = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic [KW-1:0] tkeep_in;
    logic [2:0]    flags_in;
    logic          aligner_en;
    logic          upstream_ready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] beat_count;
    logic          err_keep;

    beat_t q[$];
    int    exp_frames;
    int    exp_beats;
    bit    exp_err;
    int    compared;
    int    mismatched;

    always #5 clk = ~clk;

    aligner_axis_out_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .tkeep_in       (tkeep_in),
        .flags_in       (flags_in),
        .aligner_en     (aligner_en),
        .upstream_ready (upstream_ready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .frame_count    (frame_count),
        .beat_count     (beat_count),
        .err_keep       (err_keep)
    );

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_in(input bit v, input bit s, input bit l, input logic [KW-1:0] k,
                          input logic [DW-1:0] d, input bit rdy);
        flags_in      = {v, s, l};
        tkeep_in      = k;
        data_in       = d;
        m_axis_tready = rdy;
    endtask

    // Advance one clock: the model pops/pushes according to the sink/source rules, then waits to the next negedge.
    task automatic tick();
        bit    rd;
        bit    wr;
        beat_t b;
        rd = (q.size() > 0) && m_axis_tready;
        wr = (q.size() < D) && flags_in[2];
        b  = {flags_in[0], tkeep_in, data_in};
        @(posedge clk);
        if (reset) begin
            if (rd) begin
                beat_t h;
                h = q.pop_front();
                if (h.last) begin
                    exp_beats  = 0;
                    exp_frames = (exp_frames + 1) % 65536;
                end else if (exp_beats < 65535) begin
                    exp_beats++;
                end
            end
            if (wr) begin
                q.push_back(b);
                if (!b.last && b.keep != {KW{1'b1}}) exp_err = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        set_in(0, 0, 0, '1, '0, 1);
        repeat (D + 2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in(0, 0, 0, '1, '0, 0);
        #2;
        compared += 7;
        if (m_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        if (aligner_en !== 1'b1) begin mismatched++; $display("FAIL reset_aligner_en got %b want 1", aligner_en); end
        if (upstream_ready !== 1'b1) begin mismatched++; $display("FAIL reset_upstream_ready got %b want 1", upstream_ready); end
        if (frame_count !== '0) begin mismatched++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
        if (beat_count !== '0) begin mismatched++; $display("FAIL reset_beat_count got %0d want 0", beat_count); end
        if (err_keep !== 1'b0) begin mismatched++; $display("FAIL reset_err_keep got %b want 0", err_keep); end
        if (m_axis_tdata !== '0) begin mismatched++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [DW-1:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = rnd_data();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, i == 2, '1, d[i], 1);
            tick();
            #1;
            compared += 2;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d[i]) begin
                mismatched++;
                $display("FAIL basic_beat%0d got v=%b %h want v=1 %h", i, m_axis_tvalid, m_axis_tdata, d[i]);
            end
            if (m_axis_tlast !== (i == 2)) begin
                mismatched++;
                $display("FAIL basic_tlast%0d got %b want %b", i, m_axis_tlast, i == 2);
            end
        end
        set_in(0, 0, 0, '1, '0, 1);
        tick();
        #1;
        compared += 3;
        if (m_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL basic_empty got %b want 0", m_axis_tvalid); end
        if (frame_count !== 16'd1) begin mismatched++; $display("FAIL basic_frame_count got %0d want 1", frame_count); end
        if (beat_count !== 16'd0) begin mismatched++; $display("FAIL basic_beat_count got %0d want 0", beat_count); end
    endtask

    task automatic test_backpressure_full();
        logic [DW-1:0] bp [5];
        bit pending;
        int j;
        for (int i = 0; i < 5; i++) bp[i] = rnd_data();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, i == 4, '1, bp[i], 0);
            #1;
            if (i == 4) begin
                compared++;
                if (aligner_en !== 1'b0) begin mismatched++; $display("FAIL bp_full_en got %b want 0", aligner_en); end
            end else begin
                tick();
            end
        end
        repeat (2) tick();
        pending = 1'b1;
        j = 0;
        for (int k = 0; k < 20 && j < 5; k++) begin
            set_in(pending, 0, 1, '1, bp[4], 1);
            #1;
            if (k == 0) begin
                compared++;
                if (aligner_en !== 1'b0) begin mismatched++; $display("FAIL full_rd_no_wr got en=%b want 0", aligner_en); end
            end
            if (k == 1) begin
                compared++;
                if (aligner_en !== 1'b1) begin mismatched++; $display("FAIL full_wr_next got en=%b want 1", aligner_en); end
            end
            if (m_axis_tvalid) begin
                compared++;
                if (m_axis_tdata !== bp[j]) begin mismatched++; $display("FAIL bp_order%0d got %h want %h", j, m_axis_tdata, bp[j]); end
                j++;
            end
            if (pending && aligner_en) pending = 1'b0;
            tick();
        end
        set_in(0, 0, 0, '1, '0, 1);
        #1;
        compared += 2;
        if (j !== 5) begin mismatched++; $display("FAIL bp_beats_out got %0d want 5", j); end
        if (m_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL bp_no_dup got tvalid=%b want 0", m_axis_tvalid); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d;
        d = rnd_data();
        set_in(1, 1, 1, '1, d, 0);
        #1;
        compared += 2;
        if (upstream_ready !== 1'b0) begin mismatched++; $display("FAIL stall_upstream got %b want 0", upstream_ready); end
        if (aligner_en !== 1'b1) begin mismatched++; $display("FAIL stall_en got %b want 1", aligner_en); end
        tick();
        #1;
        compared++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d) begin
            mismatched++;
            $display("FAIL stall_capture got v=%b %h want v=1 %h", m_axis_tvalid, m_axis_tdata, d);
        end
        drain();
    endtask

    task automatic test_err_keep();
        set_in(1, 0, 1, 32'h0000FFFF, rnd_data(), 1);
        tick();
        #1;
        compared += 2;
        if (err_keep !== 1'b0) begin mismatched++; $display("FAIL keep_last_partial got %b want 0", err_keep); end
        if (m_axis_tkeep !== 32'h0000FFFF) begin mismatched++; $display("FAIL keep_out got %h want 0000ffff", m_axis_tkeep); end
        set_in(1, 0, 0, 32'h0000FFFF, rnd_data(), 1);
        tick();
        #1;
        compared++;
        if (err_keep !== 1'b1) begin mismatched++; $display("FAIL keep_nonlast_partial got %b want 1", err_keep); end
        set_in(1, 0, 1, '1, rnd_data(), 1);
        tick();
        drain();
        #1;
        compared++;
        if (err_keep !== 1'b1) begin mismatched++; $display("FAIL keep_sticky got %b want 1", err_keep); end
    endtask

    task automatic test_random();
        bit            held;
        bit            v, s, l, rdy;
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        held = 1'b0;
        v = 0; s = 0; l = 0; k = '1; d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                v = $urandom_range(0, 3) != 0;
                s = $urandom_range(0, 3) == 0;
                l = $urandom_range(0, 3) == 0;
                k = ($urandom_range(0, 7) == 0) ? KW'($urandom) : '1;
                d = rnd_data();
            end
            rdy = $urandom_range(0, 3) != 0;
            set_in(v, s, l, k, d, rdy);
            #1;
            compared += 6;
            if (m_axis_tvalid !== (q.size() > 0)) begin mismatched++; $display("FAIL rnd_tvalid c%0d got %b want %b", c, m_axis_tvalid, q.size() > 0); end
            if (aligner_en !== (q.size() < D)) begin mismatched++; $display("FAIL rnd_en c%0d got %b want %b", c, aligner_en, q.size() < D); end
            if (upstream_ready !== ((q.size() < D) && !s)) begin mismatched++; $display("FAIL rnd_upstream c%0d got %b", c, upstream_ready); end
            if (frame_count !== CW'(exp_frames)) begin mismatched++; $display("FAIL rnd_frames c%0d got %0d want %0d", c, frame_count, exp_frames); end
            if (beat_count !== CW'(exp_beats)) begin mismatched++; $display("FAIL rnd_beats c%0d got %0d want %0d", c, beat_count, exp_beats); end
            if (err_keep !== exp_err) begin mismatched++; $display("FAIL rnd_err c%0d got %b want %b", c, err_keep, exp_err); end
            if (q.size() > 0) begin
                compared++;
                if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== q[0]) begin
                    mismatched++;
                    $display("FAIL rnd_head c%0d got %b/%h/%h want %b/%h/%h", c, m_axis_tlast, m_axis_tkeep,
                             m_axis_tdata, q[0].last, q[0].keep, q[0].data);
                end
            end
            held = v && (q.size() >= D);
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid_frame();
        set_in(1, 0, 0, '1, rnd_data(), 1);
        tick();
        tick();
        set_in(1, 0, 0, '1, rnd_data(), 0);
        tick();
        set_in(1, 0, 0, '1, rnd_data(), 0);
        tick();
        set_in(0, 0, 0, '1, '0, 0);
        #1;
        compared++;
        if (m_axis_tvalid !== 1'b1 || beat_count !== 16'd1) begin
            mismatched++;
            $display("FAIL midrst_setup got v=%b beats=%0d want v=1 beats=1", m_axis_tvalid, beat_count);
        end
        reset = 1'b0;
        #1;
        compared += 5;
        if (m_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL midrst_tvalid got %b want 0", m_axis_tvalid); end
        if (frame_count !== '0) begin mismatched++; $display("FAIL midrst_frames got %0d want 0", frame_count); end
        if (beat_count !== '0) begin mismatched++; $display("FAIL midrst_beats got %0d want 0", beat_count); end
        if (aligner_en !== 1'b1) begin mismatched++; $display("FAIL midrst_en got %b want 1", aligner_en); end
        if (err_keep !== 1'b0) begin mismatched++; $display("FAIL midrst_err got %b want 0", err_keep); end
        q.delete();
        exp_frames = 0;
        exp_beats  = 0;
        exp_err    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        set_in(0, 0, 0, '1, '0, 1);
        tick();
        #1;
        compared++;
        if (m_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL midrst_no_partial got %b want 0", m_axis_tvalid); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        exp_frames = 0;
        exp_beats  = 0;
        exp_err    = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure_full();
        test_stall();
        test_err_keep();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
